decoder_3to8_reg: RTL and testbench
===================================

DECODER_3TO8_REG -- requirements
Module: decoder_3to8_reg

Interface
REQ-001 Parameters: none; all widths fixed (3-bit select, 8-bit one-hot output).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for the output register.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears the registered output.
REQ-005 Port: en  input  1  decoder enable; 0 forces all outputs low.
REQ-006 Port: in  input  3  binary select; in[2] is the MSB.
REQ-007 Port: out_comb  output  8  combinational one-hot decode of in, gated by en.
REQ-008 Port: out  output  8  registered copy of out_comb.

Function
REQ-009 out_comb SHALL equal 8'b1 << in when en=1, and 8'h00 when en=0, with no clock involvement.
REQ-010 out_comb SHALL use a hierarchical structure:
- 1-to-2 stage: decodes in[2] under en; output bit 0 active for in[2]=0, bit 1 for in[2]=1.
- Two 2-to-4 stages: each decodes in[1:0] and is enabled by one 1-to-2 output.
- Low 2-to-4 stage drives out_comb[3:0]; high stage drives out_comb[7:4].
REQ-011 The 1-to-2 stage SHALL drive both outputs low when its enable is 0.
REQ-012 Each 2-to-4 stage SHALL drive all four outputs low when its enable is 0; when enabled, only bit in[1:0] is high.
REQ-013 At most one bit of out_comb SHALL be high at any time; exactly one when en=1.
REQ-014 out SHALL load out_comb on every rising clk edge while reset=0; latency is one cycle from in/en change to out.
REQ-015 out SHALL hold its value between rising edges regardless of changes on in or en.
REQ-016 Deasserting en SHALL make out_comb 8'h00 immediately and out 8'h00 after the next rising edge.
REQ-017 If in and en change together, out SHALL reflect only the values present at the sampling edge.
REQ-018 No state other than the 8-bit out register SHALL exist; there is no handshake and no back-pressure.

Reset
REQ-019 Asserting reset SHALL force out to 8'h00 immediately, without waiting for clk.
REQ-020 While reset=1, out SHALL remain 8'h00 at every clk edge.
REQ-021 Reset SHALL NOT affect out_comb; out_comb stays a pure function of en and in.
REQ-022 After reset is released, the first rising edge SHALL load out from out_comb normally.
REQ-023 Reset asserted mid-operation (out nonzero) SHALL clear out asynchronously.

Verification
REQ-024 Enable low:
- reset pulse, en=0, in=3'b000 -> out_comb=8'h00.
- After an edge -> out=8'h00.
REQ-025 Full sweep:
- en=1, in stepped 0..7, one value per cycle.
- Each step: out_comb = 01, 02, 04, 08, 10, 20, 40, 80 (hex) immediately.
- out shows the same value one edge later.
REQ-026 Boundary selects:
- en=1, in=3'b011 -> out_comb=8'h08 (low stage only).
- in=3'b100 -> out_comb=8'h10 (high stage only).
- Never two bits high.
REQ-027 Enable drop:
- en=1, in=3'b110, out=8'h40; then en=0.
- out_comb=8'h00 at once; out=8'h40 until the next edge, then 8'h00.
REQ-028 Async reset:
- out=8'h80 with en=1, in=3'b111; assert reset between edges.
- out=8'h00 before the next edge; out_comb stays 8'h80.
- Release reset -> out=8'h80 after the next edge.

Source files
------------

// File: rtl/decoder_3to8_reg.sv
// rtl/decoder_3to8_reg.sv - hierarchical 3-to-8 one-hot decoder with registered output
module decoder_1to2 (
    input  logic       en,
    input  logic       sel,
    output logic [1:0] y
);
    // Bit 0 selects the low half, bit 1 the high half; both low when disabled.
    always_comb begin
        y = 2'b00;
        if (en) begin
            y[sel] = 1'b1;
        end
    end
endmodule

module decoder_2to4 (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] y
);
    // Only the selected bit goes high, and only while enabled.
    always_comb begin
        y = 4'b0000;
        if (en) begin
            y[sel] = 1'b1;
        end
    end
endmodule

module decoder_3to8_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] in,
    output logic [7:0] out_comb,
    output logic [7:0] out
);
    logic [1:0] half_en;

    decoder_1to2 u_top (
        .en  (en),
        .sel (in[2]),
        .y   (half_en)
    );

    decoder_2to4 u_low (
        .en  (half_en[0]),
        .sel (in[1:0]),
        .y   (out_comb[3:0])
    );

    decoder_2to4 u_high (
        .en  (half_en[1]),
        .sel (in[1:0]),
        .y   (out_comb[7:4])
    );

    // Output register: cleared asynchronously by reset, otherwise samples the decode every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= 8'h00;
        end else begin
            out <= out_comb;
        end
    end
endmodule

// File: tb/tb_decoder_3to8_reg.sv
// tb/tb_decoder_3to8_reg.sv - directed self-checking bench for decoder_3to8_reg
module tb_decoder_3to8_reg;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] in;
    logic [7:0] out_comb;
    logic [7:0] out;

    int tests_run    = 0;
    int tests_failed = 0;

    decoder_3to8_reg dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .in       (in),
        .out_comb (out_comb),
        .out      (out)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b0;
        in    = 3'b000;
        #1;
        tests_run++;
        if (out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_async_out: got %h expected %h", out, 8'h00);
        end
        en = 1'b1;
        in = 3'b101;
        @(posedge clk); #1;
        tests_run++;
        if (out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_hold_out: got %h expected %h", out, 8'h00);
        end
        tests_run++;
        if (out_comb !== 8'h20) begin
            tests_failed++;
            $display("FAIL reset_comb_unaffected: got %h expected %h", out_comb, 8'h20);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (out !== 8'h20) begin
            tests_failed++;
            $display("FAIL reset_release_load: got %h expected %h", out, 8'h20);
        end
    endtask

    task automatic test_enable_low();
        @(negedge clk);
        en = 1'b0;
        in = 3'b000;
        #1;
        tests_run++;
        if (out_comb !== 8'h00) begin
            tests_failed++;
            $display("FAIL en_low_comb: got %h expected %h", out_comb, 8'h00);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out !== 8'h00) begin
            tests_failed++;
            $display("FAIL en_low_out: got %h expected %h", out, 8'h00);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_tab [8];
        logic [7:0] prev;
        exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        prev = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en = 1'b1;
            in = 3'(i);
            #1;
            tests_run++;
            if (out_comb !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL sweep_comb[%0d]: got %h expected %h", i, out_comb, exp_tab[i]);
            end
            tests_run++;
            if (out !== prev) begin
                tests_failed++;
                $display("FAIL sweep_hold[%0d]: got %h expected %h", i, out, prev);
            end
            @(posedge clk); #1;
            tests_run++;
            if (out !== exp_tab[i]) begin
                tests_failed++;
                $display("FAIL sweep_out[%0d]: got %h expected %h", i, out, exp_tab[i]);
            end
            prev = exp_tab[i];
        end
    endtask

    task automatic test_boundary();
        @(negedge clk);
        en = 1'b1;
        in = 3'b011;
        #1;
        tests_run++;
        if (out_comb !== 8'h08) begin
            tests_failed++;
            $display("FAIL boundary_011: got %h expected %h", out_comb, 8'h08);
        end
        in = 3'b100;
        #1;
        tests_run++;
        if (out_comb !== 8'h10) begin
            tests_failed++;
            $display("FAIL boundary_100: got %h expected %h", out_comb, 8'h10);
        end
        tests_run++;
        if ($countones(out_comb) != 1) begin
            tests_failed++;
            $display("FAIL boundary_onehot: got %0d bits expected 1", $countones(out_comb));
        end
    endtask

    task automatic test_enable_drop();
        @(negedge clk);
        en = 1'b1;
        in = 3'b110;
        @(posedge clk); #1;
        tests_run++;
        if (out !== 8'h40) begin
            tests_failed++;
            $display("FAIL drop_initial_out: got %h expected %h", out, 8'h40);
        end
        @(negedge clk);
        en = 1'b0;
        #1;
        tests_run++;
        if (out_comb !== 8'h00) begin
            tests_failed++;
            $display("FAIL drop_comb: got %h expected %h", out_comb, 8'h00);
        end
        tests_run++;
        if (out !== 8'h40) begin
            tests_failed++;
            $display("FAIL drop_out_hold: got %h expected %h", out, 8'h40);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out !== 8'h00) begin
            tests_failed++;
            $display("FAIL drop_out_cleared: got %h expected %h", out, 8'h00);
        end
    endtask

    task automatic test_hold_and_simultaneous();
        @(negedge clk);
        en = 1'b1;
        in = 3'b001;
        @(posedge clk); #1;
        in = 3'b010;
        #1;
        en = 1'b0;
        #1;
        in = 3'b111;
        en = 1'b1;
        #1;
        tests_run++;
        if (out !== 8'h02) begin
            tests_failed++;
            $display("FAIL hold_between_edges: got %h expected %h", out, 8'h02);
        end
        en = 1'b0;
        in = 3'b000;
        @(negedge clk);
        en = 1'b1;
        in = 3'b010;
        @(posedge clk); #1;
        tests_run++;
        if (out !== 8'h04) begin
            tests_failed++;
            $display("FAIL simultaneous_change: got %h expected %h", out, 8'h04);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        en = 1'b1;
        in = 3'b111;
        @(posedge clk); #1;
        tests_run++;
        if (out !== 8'h80) begin
            tests_failed++;
            $display("FAIL async_pre_out: got %h expected %h", out, 8'h80);
        end
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (out !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_clear: got %h expected %h", out, 8'h00);
        end
        tests_run++;
        if (out_comb !== 8'h80) begin
            tests_failed++;
            $display("FAIL async_comb_kept: got %h expected %h", out_comb, 8'h80);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (out !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_release_hold: got %h expected %h", out, 8'h00);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out !== 8'h80) begin
            tests_failed++;
            $display("FAIL async_reload: got %h expected %h", out, 8'h80);
        end
    endtask

    initial begin
        test_reset();
        test_enable_low();
        test_sweep();
        test_boundary();
        test_enable_drop();
        test_hold_and_simultaneous();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
